tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Plays a short melody by stepping through a small buffer of {note code, duration} entries.
- Drives the 8-bit note code into the existing switch-to-maxcount tone decoder in place of the board switches.
- The decoder and slow-clock divider downstream are unchanged. Note code 0x00 means silence (maxcount 0).
- Entries are loaded while idle; START plays them in order, optionally looping.

Parameters:
DEPTH, 16, number of buffer entries (power of 2, 2..64)
TICK_DIV, 1000000, CLK cycles per duration tick (10 ms at 100 MHz)
DUR_W, 8, width of the per-entry duration field in ticks

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
WR_EN  in  1  write one entry at index COUNT (honoured only in IDLE)
WR_NOTE  in  8  note code for the entry (decoder code, 0x00 = rest)
WR_DUR  in  DUR_W  entry duration in ticks
CLEAR  in  1  empty the buffer (honoured only in IDLE)
START  in  1  begin playback from entry 0
STOP  in  1  abort playback
LOOP  in  1  restart at entry 0 after the last entry
NOTE  out  8  note code to the tone decoder
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse when playback ends naturally
FULL  out  1  COUNT == DEPTH
COUNT  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async, RST_N low) sets:
  - outputs: NOTE=0, BUSY=0, DONE=0, COUNT=0, FULL=0
  - internal: state IDLE, index=0, tick counter=0, duration counter=0
  - Buffer contents are don't-care after reset.
- States: IDLE, PLAY, GAP. All outputs are registered.
- IDLE:
  - WR_EN with FULL=0: store {WR_NOTE, WR_DUR} at index COUNT; COUNT increments.
  - WR_EN with FULL=1: ignored; COUNT is unchanged.
  - CLEAR sets COUNT=0. CLEAR and WR_EN in the same cycle: CLEAR wins and the write is dropped.
  - START with COUNT>0 at edge k: at edge k+1, state=PLAY, BUSY=1, index=0, NOTE=entry[0].note, counters loaded.
  - START with COUNT==0: DONE pulses at edge k+1; state stays IDLE.
- In PLAY or GAP:
  - WR_EN and CLEAR are ignored.
  - START is ignored (no restart).
- PLAY:
  - NOTE is held for exactly dur*TICK_DIV CLK cycles.
  - Tick counter runs 0..TICK_DIV-1. The duration counter decrements at each wrap.
  - When the duration expires, advance. Advance target is GAP if GAP_EN is defined, else the next entry directly.
  - Entry with dur==0 is skipped: it takes one cycle with NOTE unchanged from the prior value, then advances.
- Advance from index i:
  - i < COUNT-1: index = i+1, load the next entry.
  - i == COUNT-1 and LOOP=1 (sampled on that cycle): index = 0.
  - i == COUNT-1 and LOOP=0: state=IDLE, NOTE=0, BUSY=0, and DONE pulses on the same edge.
- STOP in PLAY or GAP: at the next edge, state=IDLE, NOTE=0, BUSY=0, no DONE. COUNT and buffer contents are preserved.
- STOP has priority over expiry and advance on the same cycle. STOP and START together in IDLE: neither acts.
- Note codes are passed through unmodified. Codes above 0x24 decode to silence downstream and are not this block's concern.
- Tick counter width is $clog2(TICK_DIV). No overflow is possible because the counter wraps explicitly at TICK_DIV-1.

Optional Feature:
- Macro: TONE_SEQ_GAP_EN.
- Defined: after each note's duration expires, enter GAP.
  - GAP holds NOTE=0 for exactly one tick (TICK_DIV cycles), then loads the next entry or finishes.
  - On the final entry with LOOP=0, there is no gap: finish directly.
  - Purpose: articulates repeated identical notes.
- Undefined: the GAP state does not exist. Notes play back-to-back and NOTE changes directly between entries on one edge.

Test Plan (TICK_DIV=4, DEPTH=4, macro undefined unless stated):
1. Write {0x01,2},{0x08,1}; START -> NOTE=0x01 for 8 cycles, then 0x08 for 4 cycles; then NOTE=0, DONE high for 1 cycle, BUSY falls on the same edge.
2. Write 5 entries -> COUNT=4, FULL=1 after the 4th; the 5th write is ignored and COUNT stays 4. CLEAR+WR_EN in the same cycle -> COUNT=0.
3. Play {0x10,3} with LOOP=1 -> NOTE=0x10 continuously; STOP at cycle 20 -> NOTE=0, BUSY=0 next edge, no DONE; COUNT=1 retained.
4. START with COUNT=0 -> DONE pulse one cycle later, BUSY stays 0. Entry {0x05,0} between {0x01,1} and {0x02,1} -> 0x05 never appears on NOTE.
5. Macro TONE_SEQ_GAP_EN defined; {0x0C,1},{0x0C,1} -> NOTE 0x0C for 4 cycles, 0x00 for 4, 0x0C for 4, then DONE with no trailing gap.
6. Assert RST_N low mid-note in PLAY -> NOTE, BUSY and COUNT go to 0 immediately, without a clock edge; after release, START with COUNT=0 gives DONE only.

Source files
------------

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a small {note, duration} buffer into the tone decoder's note-code input.
// Define TONE_SEQ_GAP_EN to insert one silent tick between notes (no gap after the final note).
module tone_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 1000000,
  parameter int DUR_W    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [7:0]             i_wr_note,
  input  logic [DUR_W-1:0]       i_wr_dur,
  input  logic                   i_clear,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_loop,
  output logic [7:0]             o_note,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

`ifdef TONE_SEQ_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PLAY} state_t;
`endif

  logic [7:0]       r_mem_note [DEPTH];
  logic [DUR_W-1:0] r_mem_dur  [DEPTH];

  state_t           r_state, w_state;
  logic [IW-1:0]    r_idx,   w_idx;
  logic [TW-1:0]    r_tick,  w_tick;
  logic [DUR_W-1:0] r_dur,   w_dur;
  logic [7:0]       r_note,  w_note;
  logic [CW-1:0]    r_count, w_count;
  logic             r_done,  w_done;
  logic             r_busy,  r_full;

  logic             w_wr;
  logic             w_tick_wrap;
  logic             w_expire;
  logic             w_is_last;
  logic [IW-1:0]    w_last_idx;
  logic [IW-1:0]    w_nxt_idx;
  logic [IW-1:0]    w_ld_idx;
  logic [DUR_W-1:0] w_ld_dur;
  logic [7:0]       w_ld_note;

  assign w_tick_wrap = (r_tick == TICK_LAST);
  // A zero-duration entry expires on its first cycle, which is how it gets skipped.
  assign w_expire    = (r_dur == '0) || (w_tick_wrap && (r_dur == DUR_W'(1)));
  assign w_last_idx  = IW'(r_count - 1'b1);
  assign w_is_last   = (r_idx == w_last_idx);
  assign w_nxt_idx   = w_is_last ? '0 : IW'(r_idx + 1'b1);
  assign w_ld_idx    = (r_state == S_IDLE) ? '0 : w_nxt_idx;
  assign w_ld_dur    = r_mem_dur[w_ld_idx];
  assign w_ld_note   = (w_ld_dur != '0) ? r_mem_note[w_ld_idx] : r_note;

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_tick  = r_tick;
    w_dur   = r_dur;
    w_note  = r_note;
    w_count = r_count;
    w_done  = 1'b0;
    w_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          if (r_count == '0) begin
            w_done = 1'b1;
          end else begin
            w_state = S_PLAY;
            w_idx   = '0;
            w_tick  = '0;
            w_dur   = w_ld_dur;
            w_note  = w_ld_note;
          end
        end else if (i_clear) begin
          w_count = '0;
        end else if (i_wr_en && (r_count != DEPTH_C)) begin
          w_wr    = 1'b1;
          w_count = r_count + 1'b1;
        end
      end
      S_PLAY: begin
        if (i_stop) begin
          w_state = S_IDLE;
          w_idx   = '0;
          w_tick  = '0;
          w_dur   = '0;
          w_note  = '0;
        end else if (w_expire) begin
          if (w_is_last && !i_loop) begin
            w_state = S_IDLE;
            w_idx   = '0;
            w_tick  = '0;
            w_dur   = '0;
            w_note  = '0;
            w_done  = 1'b1;
          end else begin
`ifdef TONE_SEQ_GAP_EN
            w_state = S_GAP;
            w_tick  = '0;
            w_note  = '0;
`else
            w_idx   = w_nxt_idx;
            w_tick  = '0;
            w_dur   = w_ld_dur;
            w_note  = w_ld_note;
`endif
          end
        end else if (w_tick_wrap) begin
          w_tick = '0;
          w_dur  = r_dur - 1'b1;
        end else begin
          w_tick = r_tick + 1'b1;
        end
      end
`ifdef TONE_SEQ_GAP_EN
      S_GAP: begin
        if (i_stop) begin
          w_state = S_IDLE;
          w_idx   = '0;
          w_tick  = '0;
          w_dur   = '0;
          w_note  = '0;
        end else if (w_tick_wrap) begin
          // Loop-vs-finish was decided on leaving PLAY; only wrap the index here.
          w_state = S_PLAY;
          w_idx   = w_nxt_idx;
          w_tick  = '0;
          w_dur   = w_ld_dur;
          w_note  = w_ld_note;
        end else begin
          w_tick = r_tick + 1'b1;
        end
      end
`endif
      default: begin
        w_state = S_IDLE;
        w_note  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tick  <= '0;
      r_dur   <= '0;
      r_note  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_tick  <= w_tick;
      r_dur   <= w_dur;
      r_note  <= w_note;
      r_count <= w_count;
      r_done  <= w_done;
      r_busy  <= (w_state != S_IDLE);
      r_full  <= (w_count == DEPTH_C);
    end
  end

  // Buffer storage carries no reset; contents are only meaningful below COUNT.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem_note[r_count[IW-1:0]] <= i_wr_note;
      r_mem_dur[r_count[IW-1:0]]  <= i_wr_dur;
    end
  end

  assign o_note  = r_note;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: IDLE-phase vector table, directed melodies, randomized playback vs. schedule model.
// Expected NOTE streams are expanded per cycle from the buffer contents (durations x TICK_DIV, gaps, skips).
module tb_tone_sequencer;

  localparam int DEPTH = 4;
  localparam int TD    = 4;
`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_note = '0;
  logic [7:0] i_wr_dur = '0;
  logic       i_clear = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_loop = 1'b0;
  logic [7:0] o_note;
  logic       o_busy;
  logic       o_done;
  logic       o_full;
  logic [2:0] o_count;

  tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .DUR_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_note(i_wr_note),
    .i_wr_dur(i_wr_dur), .i_clear(i_clear), .i_start(i_start), .i_stop(i_stop),
    .i_loop(i_loop), .o_note(o_note), .o_busy(o_busy), .o_done(o_done),
    .o_full(o_full), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_note [DEPTH];
  logic [7:0] m_dur  [DEPTH];
  int         m_count = 0;

  typedef struct {
    logic       wr, clr, st, sp;
    logic [7:0] nt, du;
    logic [2:0] cnt;
    logic       full, busy, done;
  } vec_t;
  vec_t vt [12];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic write_entry(input logic [7:0] nt, input logic [7:0] du);
    i_wr_en = 1'b1; i_wr_note = nt; i_wr_dur = du;
    tick();
    i_wr_en = 1'b0;
    if (m_count < DEPTH) begin
      m_note[m_count] = nt;
      m_dur[m_count]  = du;
      m_count++;
    end
    check("wr_count_full", {o_count, o_full}, {3'(m_count), (m_count == DEPTH)});
  endtask

  task automatic clear_buf();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    m_count = 0;
    check("clear_count", {o_count, o_full}, 4'b0);
  endtask

  // Runs one playback; stop_at/poke_at are cycle indices into the expected schedule (-1 = none).
  task automatic play(input bit lp, input int stop_at, input int poke_at);
    logic [7:0] sched [$];
    logic [7:0] prev;
    int         i;
    bit         last;
    bit         stopped;
    i_loop = lp;
    if (m_count == 0) begin
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("empty_start", {o_busy, o_done, o_note}, {1'b0, 1'b1, 8'h00});
      tick();
      check("empty_done_drop", {o_busy, o_done}, 2'b00);
      return;
    end
    prev = 8'h00;
    i = 0;
    forever begin
      if (m_dur[i] == 0) sched.push_back(prev);
      else repeat (int'(m_dur[i]) * TD) sched.push_back(m_note[i]);
      prev = sched[sched.size()-1];
      last = (i == m_count - 1);
      if (last && !lp) break;
      if (GAP) begin
        repeat (TD) sched.push_back(8'h00);
        prev = 8'h00;
      end
      i = last ? 0 : i + 1;
      if (lp && sched.size() > stop_at) break;
    end
    stopped = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < sched.size(); c++) begin
      check($sformatf("play_c%0d", c), {o_busy, o_done, o_note}, {1'b1, 1'b0, sched[c]});
      if (c == stop_at) begin
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("stop_idle", {o_busy, o_done, o_note}, 10'b0);
        stopped = 1'b1;
        break;
      end
      if (c == poke_at && c < sched.size() - 1) begin
        i_wr_en = 1'b1; i_wr_note = 8'($urandom); i_wr_dur = 8'($urandom_range(0, 3));
        i_clear = 1'($urandom_range(0, 1)); i_start = 1'b1;
      end
      tick();
      i_wr_en = 1'b0; i_clear = 1'b0; i_start = 1'b0;
    end
    if (!stopped) begin
      check("finish", {o_busy, o_done, o_note}, {1'b0, 1'b1, 8'h00});
      tick();
      check("done_pulse_1cyc", {o_busy, o_done}, 2'b00);
    end else begin
      tick();
      check("stop_no_done", {o_busy, o_done}, 2'b00);
    end
    check("count_kept", o_count, m_count);
    i_loop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  lp;
    int  stop_at;

    vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'd2, 3'd1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 8'd1, 3'd2, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'd3, 3'd3, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'd1, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'd1, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h23, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'd1, 3'd1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1};

    #12;
    check("reset_outputs", {o_note, o_busy, o_done, o_full, o_count}, 14'b0);
    i_rst_n = 1'b1;
    tick();

    for (int k = 0; k < 12; k++) begin
      i_wr_en = vt[k].wr; i_clear = vt[k].clr; i_start = vt[k].st; i_stop = vt[k].sp;
      i_wr_note = vt[k].nt; i_wr_dur = vt[k].du;
      tick();
      i_wr_en = 1'b0; i_clear = 1'b0; i_start = 1'b0; i_stop = 1'b0;
      check($sformatf("vec%0d", k), {o_count, o_full, o_busy, o_done},
            {vt[k].cnt, vt[k].full, vt[k].busy, vt[k].done});
    end
    m_count = 0;

    // Two-entry melody to natural completion.
    clear_buf();
    write_entry(8'h01, 8'd2);
    write_entry(8'h08, 8'd1);
    play(1'b0, -1, -1);

    // Looping single note aborted by STOP.
    clear_buf();
    write_entry(8'h10, 8'd3);
    play(1'b1, 20, 7);

    // Zero-duration entry is skipped without showing its code.
    clear_buf();
    write_entry(8'h01, 8'd1);
    write_entry(8'h05, 8'd0);
    write_entry(8'h02, 8'd1);
    play(1'b0, -1, -1);

    // Repeated identical notes (articulated when gaps are enabled).
    clear_buf();
    write_entry(8'h0C, 8'd1);
    write_entry(8'h0C, 8'd1);
    play(1'b0, -1, -1);

    // Asynchronous reset mid-note.
    clear_buf();
    write_entry(8'h01, 8'd2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_note", o_note, 8'h00);
    check("async_rst_busy", o_busy, 1'b0);
    check("async_rst_count", o_count, 3'd0);
    #1 i_rst_n = 1'b1;
    m_count = 0;
    tick();
    play(1'b0, -1, -1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) clear_buf();
      n = $urandom_range(0, 3);
      repeat (n) write_entry(8'($urandom_range(0, 8'h30)), 8'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) begin
        i_clear = 1'b1; i_wr_en = 1'b1; i_wr_note = 8'h11; i_wr_dur = 8'd1;
        tick();
        i_clear = 1'b0; i_wr_en = 1'b0;
        m_count = 0;
        check("rand_clr_wr", o_count, 3'd0);
      end
      lp = 1'($urandom_range(0, 1));
      if (lp) stop_at = $urandom_range(0, 40);
      else if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(0, 30);
      else stop_at = -1;
      play(lp, stop_at, $urandom_range(0, 30));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
